muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EX stage, replacing the fixed 32-bit divider handshake with one block that handles MULT/MULTU/DIV/DIVU and the accumulate forms MADD/MADDU/MSUB/MSUBU. It sits beside the ALU. EX asserts `start` with operands and uses `busy_o` as its stall request. The `{HI,LO}` result returns with a one-cycle `ready_o` pulse and goes to the HI/LO write path.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_unit_div_core.sv | 67 ++++++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - operation codes, FSM states and helpers for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  // Operations that treat opa/opb as two's-complement values
  function automatic logic is_signed(input op_e f_op);
    case (f_op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input op_e f_op);
    return (f_op == OP_DIV) || (f_op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_kill,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quot_nx;

  // Shift the next dividend bit into the partial remainder and try the subtract
  assign w_shift   = {r_rem, r_quot[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

  // Results are taken from the final iteration's combinational outputs so the
  // owner can register them on the same edge the last bit is produced
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_quot = w_quot_nx;
  assign o_rem  = w_rem_nx;

  // Iteration state: load on start, step while busy, stop on kill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
    end else if (i_kill) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH);
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/DIV/MADD/MSUB unit with {HI,LO} result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  state_e             r_state;
  op_e                r_op;
  logic [2*WIDTH-1:0] r_hilo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg;
  logic               r_neg_rem;
  logic [1:0]         r_cnt;
  logic [2*WIDTH-1:0] r_pend;
  logic               r_pend_dz;
  logic [2*WIDTH-1:0] r_result;

  op_e                w_op;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_accept;
  logic               w_is_div;
  logic               w_dz;
  logic [2*WIDTH-1:0] w_prod_in;
  logic [2*WIDTH-1:0] w_prod0;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic               w_core_done;
  logic [WIDTH-1:0]   w_core_quot;
  logic [WIDTH-1:0]   w_core_rem;
  logic [WIDTH-1:0]   w_div_quot;
  logic [WIDTH-1:0]   w_div_rem;

  // Sign/magnitude split of the incoming operands; -x of the most negative value wraps to itself
  assign w_op     = op_e'(op);
  assign w_sa     = is_signed(w_op) & opa[WIDTH-1];
  assign w_sb     = is_signed(w_op) & opb[WIDTH-1];
  assign w_abs_a  = w_sa ? -opa : opa;
  assign w_abs_b  = w_sb ? -opb : opb;
  assign w_is_div = is_div(w_op);
  assign w_dz     = (opb == '0);
  assign w_accept = (r_state == S_IDLE) && start && !annul_i;

  // Unsigned product; w_prod_in serves the single-cycle configuration only
  assign w_prod_in = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
  assign w_prod0   = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  generate
    if (MUL_LAT >= 3) begin : g_pipe
      logic [2*WIDTH-1:0] r_pstage [MUL_LAT-2];
      // Extra product register stages for longer multiply latencies
      always_ff @(posedge clk) begin
        r_pstage[0] <= w_prod0;
        for (int i = 1; i < MUL_LAT - 2; i++) r_pstage[i] <= r_pstage[i-1];
      end
      assign w_mul_prod = r_pstage[MUL_LAT-3];
    end else begin : g_nopipe
      assign w_mul_prod = w_prod0;
    end
  endgenerate

  // Apply product sign, then accumulate into or subtract from {HI,LO}
  function automatic logic [2*WIDTH-1:0] mul_final(input op_e f_op,
                                                    input logic [2*WIDTH-1:0] f_hilo,
                                                    input logic [2*WIDTH-1:0] f_prod,
                                                    input logic f_neg);
    logic [2*WIDTH-1:0] s;
    s = f_neg ? -f_prod : f_prod;
    case (f_op)
      OP_MADD, OP_MADDU: return f_hilo + s;
      OP_MSUB, OP_MSUBU: return f_hilo - s;
      default:           return s;
    endcase
  endfunction

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept && w_is_div && !w_dz),
    .i_kill     (annul_i),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_done     (w_core_done),
    .o_quot     (w_core_quot),
    .o_rem      (w_core_rem)
  );

  // Quotient follows the sign product, remainder follows the dividend
  assign w_div_quot = r_neg ? -w_core_quot : w_core_quot;
  assign w_div_rem  = r_neg_rem ? -w_core_rem : w_core_rem;

  // The pending result is visible only in an un-annulled DONE cycle and committed at its end
  assign busy_o        = (r_state != S_IDLE);
  assign ready_o       = (r_state == S_DONE) && !annul_i;
  assign result_o      = ready_o ? r_pend : r_result;
  assign div_by_zero_o = ready_o && r_pend_dz;

  // Control FSM: accept, multiply countdown, divide wait, result commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MULT;
      r_hilo    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_dz <= 1'b0;
      r_result  <= '0;
    end else if (annul_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= w_op;
            r_hilo    <= hilo_i;
            r_a       <= w_abs_a;
            r_b       <= w_abs_b;
            r_neg     <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_pend_dz <= 1'b0;
            if (w_is_div) begin
              if (w_dz) begin
                r_pend    <= {opa, {WIDTH{1'b1}}};
                r_pend_dz <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_state <= S_DIV;
              end
            end else if (MUL_LAT == 1) begin
              r_pend  <= mul_final(w_op, hilo_i, w_prod_in, w_sa ^ w_sb);
              r_state <= S_DONE;
            end else begin
              r_cnt   <= 2'(MUL_LAT - 2);
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == 2'd0) begin
            r_pend  <= mul_final(r_op, r_hilo, w_mul_prod, r_neg);
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_DIV: begin
          if (w_core_done) begin
            r_pend  <= {w_div_rem, w_div_quot};
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_result <= r_pend;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] hilo_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;
  logic        div_by_zero_o;

  int checks;
  int failures;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .opa           (opa),
    .opb           (opb),
    .hilo_i        (hilo_i),
    .annul_i       (annul_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .result_o      (result_o),
    .div_by_zero_o (div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] h;
    logic [63:0] exp;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions of each operation
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h, output logic [63:0] r, output logic dz,
                       output int lat);
    longint sp;
    logic [63:0] up;
    int ia, ib, q, rm;
    sp = longint'(signed'(a)) * longint'(signed'(b));
    up = {32'd0, a} * {32'd0, b};
    dz = 1'b0;
    lat = 2;
    case (o)
      3'd0: r = sp;
      3'd1: r = up;
      3'd4: r = h + sp;
      3'd5: r = h + up;
      3'd6: r = h - sp;
      3'd7: r = h - up;
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
          lat = 1;
        end else begin
          lat = 33;
          if (o == 3'd3) begin
            r = {a % b, a / b};
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'd0, 32'h8000_0000};
          end else begin
            ia = int'(a);
            ib = int'(b);
            q  = ia / ib;
            rm = ia % ib;
            r  = {32'(rm), 32'(q)};
          end
        end
      end
    endcase
  endtask

  // Present one operation in the current cycle and wait for its ready pulse
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, output logic [63:0] res, output logic dz,
                        output int lat, output int busy_bad);
    res = '0;
    dz = 1'b0;
    lat = -1;
    busy_bad = 0;
    start = 1'b1;
    op = o;
    opa = a;
    opb = b;
    hilo_i = h;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom);
    opa = $urandom;
    opb = $urandom;
    hilo_i = {$urandom, $urandom};
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy_o !== 1'b1) busy_bad++;
      if (ready_o === 1'b1) begin
        lat = c;
        res = result_o;
        dz = div_by_zero_o;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  vec_t        vecs [10];
  logic [63:0] res, exp_r, last_exp;
  logic        dz, exp_dz;
  int          lat, exp_lat, busy_bad, seen;
  logic [2:0]  ro;
  logic [31:0] ra, rb;
  logic [63:0] rh;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    opa = '0;
    opb = '0;
    hilo_i = '0;
    annul_i = 1'b0;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, 1'b0, 2};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33};
    vecs[3] = '{3'd3, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 1'b0, 33};
    vecs[4] = '{3'd4, 32'd3, 32'd4, 64'd5, 64'h0000_0000_0000_0011, 1'b0, 2};
    vecs[5] = '{3'd7, 32'd3, 32'd4, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 2};
    vecs[6] = '{3'd3, 32'h1234, 32'd0, 64'd0, 64'h0000_1234_FFFF_FFFF, 1'b1, 1};
    vecs[7] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 33};
    vecs[8] = '{3'd2, 32'h8000_0000, 32'd0, 64'd0, 64'h8000_0000_FFFF_FFFF, 1'b1, 1};
    vecs[9] = '{3'd6, 32'hFFFF_FFFD, 32'd4, 64'd0, 64'h0000_0000_0000_000C, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_dz", 64'(div_by_zero_o), 64'd0);
    rst = 1'b0;

    // Directed vectors, issued back-to-back
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, res, dz, lat, busy_bad);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].exp_dz));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_busy", i), 64'(busy_bad), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle_after", i), 64'(busy_o), 64'd0);
    end
    last_exp = vecs[9].exp;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      rh = {$urandom, $urandom};
      model(ro, ra, rb, rh, exp_r, exp_dz, exp_lat);
      run_op(ro, ra, rb, rh, res, dz, lat, busy_bad);
      chk($sformatf("rnd%0d_op%0d_result", i, ro), res, exp_r);
      chk($sformatf("rnd%0d_dz", i), 64'(dz), 64'(exp_dz));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat));
      last_exp = exp_r;
      @(posedge clk); #1;
    end

    // DIV annulled at t+10, start at t+5 ignored, new MULT accepted at t+11
    start = 1'b1; op = 3'd2; opa = 32'd1000; opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin start = 1'b1; op = 3'd0; opa = 32'd5; opb = 32'd6; end
      if (c == 6) start = 1'b0;
      if (c == 10) annul_i = 1'b1;
      @(negedge clk);
      if (ready_o === 1'b1) seen++;
      @(posedge clk); #1;
    end
    annul_i = 1'b0;
    chk("annul_idle", 64'(busy_o), 64'd0);
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result_kept", result_o, last_exp);
    run_op(3'd0, 32'd5, 32'd6, 64'd0, res, dz, lat, busy_bad);
    chk("after_annul_mult_result", res, 64'd30);
    chk("after_annul_mult_latency", 64'(lat), 64'd2);
    last_exp = 64'd30;

    // Annul in the DONE cycle suppresses ready and keeps the old result
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; opa = 32'd7; opb = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(negedge clk);
    chk("done_annul_ready", 64'(ready_o), 64'd0);
    chk("done_annul_result", result_o, last_exp);
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("done_annul_idle", 64'(busy_o), 64'd0);
    chk("done_annul_result_after", result_o, last_exp);

    // Start together with annul in IDLE is not accepted
    start = 1'b1; annul_i = 1'b1; op = 3'd0; opa = 32'd2; opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; annul_i = 1'b0;
    chk("idle_annul_not_accepted", 64'(busy_o), 64'd0);

    // Reset in the middle of a divide
    start = 1'b1; op = 3'd2; opa = 32'd100; opb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_busy", 64'(busy_o), 64'd0);
    chk("midreset_ready", 64'(ready_o), 64'd0);
    chk("midreset_result", result_o, 64'd0);
    chk("midreset_dz", 64'(div_by_zero_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd3, 32'd100, 32'd7, 64'd0, res, dz, lat, busy_bad);
    chk("post_reset_divu_result", res, 64'h0000_0002_0000_000E);
    chk("post_reset_divu_latency", 64'(lat), 64'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
